// File: rtl/player_draw_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : player_draw_ctl                                            |
// | Description : Three-stage sprite overlay for a VGA pixel stream, with    |
// |               mirrored-image select and a frame-based blink sequence.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module player_draw_ctl #(
  parameter int          SPRITE_SIZE  = 64,
  parameter logic [11:0] TRANSPARENT  = 12'hF0F,
  parameter int          BLINK_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        facing_left,
  input  logic        blink_req,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_rgb,
  input  logic [11:0] rom_rgb2,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SHOW = 2'd1;
  localparam logic [1:0] c_HIDE = 2'd2;
  localparam int         c_FCW  = $clog2(BLINK_FRAMES + 1);
  localparam logic [11:0] c_SIZE = 12'(SPRITE_SIZE);

  // Blink FSM state and counters
  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [c_FCW-1:0] r_frame_cnt;
  logic [c_FCW-1:0] w_frame_cnt_next;
  logic [1:0]       r_phase_cnt;
  logic [1:0]       w_phase_next;
  logic             w_visible;

  // Per-frame latched parameters
  logic [11:0] r_x_l;
  logic [11:0] r_y_l;
  logic        r_face_l;
  logic        r_vis_l;

  // Stage 1 / stage 2 pipeline registers
  logic [10:0] r_s1_hcount, r_s2_hcount;
  logic [10:0] r_s1_vcount, r_s2_vcount;
  logic        r_s1_hsync,  r_s2_hsync;
  logic        r_s1_vsync,  r_s2_vsync;
  logic        r_s1_hblnk,  r_s2_hblnk;
  logic        r_s1_vblnk,  r_s2_vblnk;
  logic [11:0] r_s1_rgb,    r_s2_rgb;
  logic        r_s1_in_spr, r_s2_in_spr;
  logic        r_s1_vis,    r_s2_vis;
  logic        r_s1_face,   r_s2_face;

  // The frame-start pixel already belongs to the new frame, so it sees the
  // live position/facing/visibility; every later pixel uses the latched copy.
  logic        w_frame_start;
  logic [11:0] w_x, w_y;
  logic        w_face, w_vis;
  logic [11:0] w_h12, w_v12, w_dx, w_dy;
  logic        w_in_sprite;
  logic [11:0] w_pix;

  assign w_frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);
  assign w_x    = w_frame_start ? xpos        : r_x_l;
  assign w_y    = w_frame_start ? ypos        : r_y_l;
  assign w_face = w_frame_start ? facing_left : r_face_l;
  assign w_vis  = w_frame_start ? w_visible   : r_vis_l;

  // Subtract only after the >= test, so x+SIZE beyond 4095 never wraps into a hit
  assign w_h12 = {1'b0, hcount_in};
  assign w_v12 = {1'b0, vcount_in};
  assign w_dx  = w_h12 - w_x;
  assign w_dy  = w_v12 - w_y;
  assign w_in_sprite = (w_h12 >= w_x) && (w_dx < c_SIZE) &&
                       (w_v12 >= w_y) && (w_dy < c_SIZE);

  assign w_pix = r_s2_face ? rom_rgb2 : rom_rgb;

  // Blink FSM state register with its frame and phase counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_frame_cnt <= '0;
      r_phase_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_frame_cnt <= w_frame_cnt_next;
      r_phase_cnt <= w_phase_next;
    end
  end

  // Blink FSM next state: a request always wins over the frame-start step
  always_comb begin
    w_state_next     = r_state;
    w_frame_cnt_next = r_frame_cnt;
    w_phase_next     = r_phase_cnt;
    if (blink_req) begin
      w_state_next     = c_HIDE;
      w_frame_cnt_next = c_FCW'(BLINK_FRAMES);
      w_phase_next     = 2'd0;
    end else if (w_frame_start && (r_state != c_IDLE)) begin
      w_frame_cnt_next = r_frame_cnt - c_FCW'(1);
      w_phase_next     = r_phase_cnt + 2'd1;
      if (r_frame_cnt == c_FCW'(1)) begin
        w_state_next = c_IDLE;
      end else if (r_phase_cnt == 2'd3) begin
        w_state_next = (r_state == c_HIDE) ? c_SHOW : c_HIDE;
      end
    end
  end

  // Blink FSM output: sprite hidden only while in HIDE
  always_comb begin
    w_visible = 1'b1;
    if (r_state == c_HIDE) begin
      w_visible = 1'b0;
    end
  end

  // Latch position, facing and visibility once per frame to avoid tearing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_l    <= '0;
      r_y_l    <= '0;
      r_face_l <= 1'b0;
      r_vis_l  <= 1'b1;
    end else if (w_frame_start) begin
      r_x_l    <= xpos;
      r_y_l    <= ypos;
      r_face_l <= facing_left;
      r_vis_l  <= w_visible;
    end
  end

  // Stage 1: hit test, ROM address and capture of the incoming pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr    <= '0;
      r_s1_hcount <= '0;
      r_s1_vcount <= '0;
      r_s1_hsync  <= 1'b0;
      r_s1_vsync  <= 1'b0;
      r_s1_hblnk  <= 1'b0;
      r_s1_vblnk  <= 1'b0;
      r_s1_rgb    <= '0;
      r_s1_in_spr <= 1'b0;
      r_s1_vis    <= 1'b0;
      r_s1_face   <= 1'b0;
    end else begin
      rom_addr    <= w_in_sprite ? {w_dy[5:0], w_dx[5:0]} : 12'h000;
      r_s1_hcount <= hcount_in;
      r_s1_vcount <= vcount_in;
      r_s1_hsync  <= hsync_in;
      r_s1_vsync  <= vsync_in;
      r_s1_hblnk  <= hblnk_in;
      r_s1_vblnk  <= vblnk_in;
      r_s1_rgb    <= rgb_in;
      r_s1_in_spr <= w_in_sprite;
      r_s1_vis    <= w_vis;
      r_s1_face   <= w_face;
    end
  end

  // Stage 2: wait out the ROM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_hcount <= '0;
      r_s2_vcount <= '0;
      r_s2_hsync  <= 1'b0;
      r_s2_vsync  <= 1'b0;
      r_s2_hblnk  <= 1'b0;
      r_s2_vblnk  <= 1'b0;
      r_s2_rgb    <= '0;
      r_s2_in_spr <= 1'b0;
      r_s2_vis    <= 1'b0;
      r_s2_face   <= 1'b0;
    end else begin
      r_s2_hcount <= r_s1_hcount;
      r_s2_vcount <= r_s1_vcount;
      r_s2_hsync  <= r_s1_hsync;
      r_s2_vsync  <= r_s1_vsync;
      r_s2_hblnk  <= r_s1_hblnk;
      r_s2_vblnk  <= r_s1_vblnk;
      r_s2_rgb    <= r_s1_rgb;
      r_s2_in_spr <= r_s1_in_spr;
      r_s2_vis    <= r_s1_vis;
      r_s2_face   <= r_s1_face;
    end
  end

  // Stage 3: composite sprite over background and drive the outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= r_s2_hcount;
      vcount_out <= r_s2_vcount;
      hsync_out  <= r_s2_hsync;
      vsync_out  <= r_s2_vsync;
      hblnk_out  <= r_s2_hblnk;
      vblnk_out  <= r_s2_vblnk;
      if (r_s2_hblnk || r_s2_vblnk) begin
        rgb_out <= 12'h000;
      end else if (r_s2_in_spr && r_s2_vis && (w_pix != TRANSPARENT)) begin
        rgb_out <= w_pix;
      end else begin
        rgb_out <= r_s2_rgb;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_player_draw_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_player_draw_ctl                                         |
// | Description : Self-checking bench for player_draw_ctl: directed vector   |
// |               table, blink/reset sequences and a random reference model. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_player_draw_ctl;

  localparam int          c_SZ    = 64;
  localparam logic [11:0] c_TR    = 12'hF0F;
  localparam int          c_BLINK = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in, xpos, ypos;
  logic        facing_left, blink_req;
  logic [11:0] rom_addr;
  logic [11:0] rom_rgb  = 12'h000;
  logic [11:0] rom_rgb2 = 12'h000;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int n_checks = 0;
  int n_errors = 0;

  player_draw_ctl #(.SPRITE_SIZE(c_SZ), .TRANSPARENT(c_TR), .BLINK_FRAMES(c_BLINK)) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .facing_left(facing_left), .blink_req(blink_req),
    .rom_addr(rom_addr), .rom_rgb(rom_rgb), .rom_rgb2(rom_rgb2),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  // Sprite ROM contents: right image has a see-through pixel wherever the low nibble is F
  function automatic logic [11:0] rom1(input logic [11:0] a);
    return (a[3:0] == 4'hF) ? c_TR : {4'hA, a[7:0]};
  endfunction
  function automatic logic [11:0] rom2(input logic [11:0] a);
    return {4'h5, a[7:0]};
  endfunction

  // One-cycle registered ROM read
  always @(posedge clk) begin
    rom_rgb  <= rom1(rom_addr);
    rom_rgb2 <= rom2(rom_addr);
  end

  typedef struct {
    bit rst; int h; int v; bit hs; bit vs; bit hb; bit vb;
    logic [11:0] rgb; int x; int y; bit face; bit blink;
  } in_t;

  typedef struct packed {
    logic [10:0] hc; logic [10:0] vc;
    logic hs; logic vs; logic hb; logic vb;
    logic [11:0] rgb;
  } out_t;

  typedef struct { in_t in; logic [11:0] exp_addr; logic [11:0] exp_rgb; } vec_t;

  // Reference model state: frame-level parameters and blink progress
  int   m_x, m_y;
  bit   m_face, m_vis, m_blinking;
  int   m_n;
  out_t hist [3];
  logic [11:0] m_addr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic in_t idle_in();
    in_t s;
    s = '{rst:0, h:300, v:300, hs:0, vs:0, hb:0, vb:0, rgb:12'h000, x:0, y:0, face:0, blink:0};
    return s;
  endfunction

  function automatic logic [63:0] dut_out();
    out_t o;
    o = '{hc:hcount_out, vc:vcount_out, hs:hsync_out, vs:vsync_out,
          hb:hblnk_out, vb:vblnk_out, rgb:rgb_out};
    return 64'(o);
  endfunction

  // Apply one pixel, advance the model, clock once, compare on the falling edge
  task automatic tick(input in_t s);
    out_t nw;
    logic [11:0] a, pix;
    bit fs, ins;
    rst = s.rst; hcount_in = 11'(s.h); vcount_in = 11'(s.v);
    hsync_in = s.hs; vsync_in = s.vs; hblnk_in = s.hb; vblnk_in = s.vb;
    rgb_in = s.rgb; xpos = 12'(s.x); ypos = 12'(s.y);
    facing_left = s.face; blink_req = s.blink;
    if (s.rst) begin
      m_x = 0; m_y = 0; m_face = 0; m_vis = 1; m_blinking = 0; m_n = 0;
      hist[0] = '0; hist[1] = '0; hist[2] = '0; m_addr = '0;
    end else begin
      fs = (s.h == 0) && (s.v == 0);
      if (fs) begin
        m_x = s.x; m_y = s.y; m_face = s.face;
        // frames 0-3 after a request hidden, 4-7 shown, alternating
        m_vis = !(m_blinking && (((m_n / 4) % 2) == 0));
      end
      if (s.blink) begin
        m_blinking = 1; m_n = 0;
      end else if (fs && m_blinking) begin
        m_n++;
        if (m_n == c_BLINK) m_blinking = 0;
      end
      ins = (s.h >= m_x) && (s.h - m_x < c_SZ) && (s.v >= m_y) && (s.v - m_y < c_SZ);
      a   = ins ? 12'(((s.v - m_y) % 64) * 64 + ((s.h - m_x) % 64)) : 12'h000;
      pix = m_face ? rom2(a) : rom1(a);
      nw.hc = 11'(s.h); nw.vc = 11'(s.v);
      nw.hs = s.hs; nw.vs = s.vs; nw.hb = s.hb; nw.vb = s.vb;
      if (s.hb || s.vb)                     nw.rgb = 12'h000;
      else if (ins && m_vis && pix != c_TR) nw.rgb = pix;
      else                                  nw.rgb = s.rgb;
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = nw;
      m_addr = a;
    end
    @(posedge clk);
    @(negedge clk);
    chk("model_out", dut_out(), 64'(hist[2]));
    chk("model_addr", 64'(rom_addr), 64'(m_addr));
  endtask

  function automatic vec_t mk(int h, int v, bit hb, int rgb, int x, int y, bit face,
                              int ea, int er);
    vec_t t;
    t.in = idle_in();
    t.in.h = h; t.in.v = v; t.in.hb = hb; t.in.rgb = 12'(rgb);
    t.in.x = x; t.in.y = y; t.in.face = face;
    t.exp_addr = 12'(ea); t.exp_rgb = 12'(er);
    return t;
  endfunction

  // One short frame: frame start, sprite pixel (110,60), two idle pixels
  task automatic run_frame(input bit exp_vis, input bit pulse, input string nm);
    in_t s;
    s = idle_in();
    s.h = 0; s.v = 0; s.x = 100; s.y = 50; s.rgb = 12'h111; tick(s);
    s.h = 110; s.v = 60; s.rgb = 12'h222; tick(s);
    s.h = 300; s.v = 300; s.rgb = 12'h333; s.blink = pulse; tick(s);
    s.blink = 0; tick(s);
    chk(nm, 64'(rgb_out), exp_vis ? 64'h A8A : 64'h222);
  endtask

  function automatic bit blink_hidden(input int k);
    int j;
    if (k <= 10) return (k >= 1) && ((((k - 1) / 4) % 2) == 0);
    j = k - 10;
    return (j <= 60) && ((((j - 1) / 4) % 2) == 0);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [15];
    logic [11:0] rq [$];
    in_t s;
    int cx, cy, hh;
    bit cf;

    // Directed vectors: {h, v, hblnk, rgb_in, xpos, ypos, facing} -> {rom_addr, rgb_out}
    tbl[0]  = mk(0,    0,   0, 'h123, 100,  50, 0, 'h000, 'h123);
    tbl[1]  = mk(110,  60,  0, 'h333, 100,  50, 0, 'h28A, 'hA8A);
    tbl[2]  = mk(110,  60,  0, 'h334, 0,    0,  1, 'h28A, 'hA8A);
    tbl[3]  = mk(99,   60,  0, 'h444, 0,    0,  1, 'h000, 'h444);
    tbl[4]  = mk(163,  113, 0, 'h555, 0,    0,  1, 'hFFF, 'h555);
    tbl[5]  = mk(164,  60,  0, 'h666, 0,    0,  1, 'h000, 'h666);
    tbl[6]  = mk(110,  60,  1, 'h777, 0,    0,  1, 'h28A, 'h000);
    tbl[7]  = mk(115,  60,  0, 'h778, 0,    0,  1, 'h28F, 'h778);
    tbl[8]  = mk(0,    0,   0, 'h888, 100,  50, 1, 'h000, 'h888);
    tbl[9]  = mk(110,  60,  0, 'h889, 100,  50, 1, 'h28A, 'h58A);
    tbl[10] = mk(0,    0,   0, 'h999, 4090, 0,  0, 'h000, 'h999);
    tbl[11] = mk(57,   10,  0, 'h0AB, 4090, 0,  0, 'h000, 'h0AB);
    tbl[12] = mk(2047, 0,   0, 'h0CD, 4090, 0,  0, 'h000, 'h0CD);
    tbl[13] = mk(0,    0,   0, 'h0EE, 2040, 0,  0, 'h000, 'h0EE);
    tbl[14] = mk(2047, 5,   0, 'h0EF, 2040, 0,  0, 'h147, 'hA47);

    // Reset state
    s = idle_in(); s.rst = 1; s.hb = 1; s.rgb = 12'hFFF;
    tick(s); tick(s);
    chk("rst_outputs", dut_out(), 64'h0);
    chk("rst_rom_addr", 64'(rom_addr), 64'h0);

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      tick(tbl[i].in);
      chk($sformatf("tbl%0d_addr", i), 64'(rom_addr), 64'(tbl[i].exp_addr));
      rq.push_back(tbl[i].exp_rgb);
      if (rq.size() == 3) chk("tbl_rgb", 64'(rgb_out), 64'(rq.pop_front()));
    end
    s = idle_in(); s.v = 500; s.h = 100;
    for (int i = 0; i < 2; i++) begin
      tick(s);
      chk("tbl_rgb_tail", 64'(rgb_out), 64'(rq.pop_front()));
    end

    // Blink sequence with a restart pulse in frame 10
    run_frame(1'b1, 1'b1, "blink_f0");
    for (int k = 1; k <= 72; k++)
      run_frame(!blink_hidden(k), k == 10, $sformatf("blink_f%0d", k));

    // Reset in the middle of a line while blinking
    run_frame(1'b1, 1'b1, "pre_rst");
    s = idle_in(); s.h = 0; s.v = 0; s.x = 100; s.y = 50; tick(s);
    s.h = 110; s.v = 60; s.rgb = 12'h222; tick(s);
    s.rst = 1; tick(s);
    chk("mid_rst_outputs", dut_out(), 64'h0);
    s.rst = 0; s.h = 5; s.v = 5; s.rgb = 12'h444; tick(s);
    chk("post_rst_addr", 64'(rom_addr), 64'h145);
    s = idle_in(); tick(s); tick(s);
    chk("post_rst_origin_pix", 64'(rgb_out), 64'hA45);
    run_frame(1'b1, 1'b0, "post_rst_visible");

    // Randomized traffic against the reference model
    cx = 100; cy = 50; cf = 0;
    for (int n = 0; n < 3000; n++) begin
      s = idle_in();
      if ($urandom_range(0, 19) == 0)
        cx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3990, 4095)) : int'($urandom_range(0, 350));
      if ($urandom_range(0, 19) == 0) cy = int'($urandom_range(0, 250));
      if ($urandom_range(0, 19) == 0) cf = ~cf;
      s.x = cx; s.y = cy; s.face = cf;
      s.rst   = ($urandom_range(0, 299) == 0);
      s.blink = ($urandom_range(0, 499) == 0);
      s.hs = 1'($urandom); s.vs = 1'($urandom);
      s.hb = ($urandom_range(0, 7) == 0); s.vb = ($urandom_range(0, 7) == 0);
      s.rgb = 12'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        s.h = 0; s.v = 0;
      end else begin
        hh = m_x + int'($urandom_range(0, 80)) - 8;
        s.h = (hh < 0) ? 0 : ((hh > 2047) ? 2047 : hh);
        hh = m_y + int'($urandom_range(0, 80)) - 8;
        s.v = (hh < 0) ? 1 : ((hh > 2047) ? 2047 : hh);
      end
      tick(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/player_draw_ctl.md
PLAYER_DRAW_CTL -- requirements
Module: player_draw_ctl

Interface
REQ-001 Parameter SPRITE_SIZE, default 64, sprite width and height in pixels; SHALL be a power of two and at most 64.
REQ-002 Parameter TRANSPARENT, default 12'hF0F, ROM pixel value treated as see-through.
REQ-003 Parameter BLINK_FRAMES, default 60, length of a blink sequence in frames.
REQ-004 Ports SHALL be:
- clk  in  1  system/pixel clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- hcount_in, vcount_in  in  11 each  VGA pixel counters.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  VGA timing.
- rgb_in  in  12  background pixel.
- xpos, ypos  in  12 each  sprite top-left corner.
- facing_left  in  1  selects the mirrored image.
- blink_req  in  1  single-cycle pulse that starts a blink sequence.
- rom_addr  out  12  sprite ROM address {row[5:0], col[5:0]}.
- rom_rgb, rom_rgb2  in  12 each  right-facing and left-facing ROM data, one-cycle registered read.
- hcount_out, vcount_out  out  11 each  delayed counters.
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing.
- rgb_out  out  12  composited pixel.

Function
REQ-005 Frame start SHALL be the cycle with hcount_in==0 and vcount_in==0.
REQ-006 xpos, ypos and facing_left SHALL be latched only at frame start, so mid-frame changes take effect from the next frame (no tearing).
REQ-007 Stage 1 (edge E) SHALL register in_sprite = (hcount_in>=x_l) && (hcount_in-x_l < SPRITE_SIZE) && (vcount_in>=y_l) && (vcount_in-y_l < SPRITE_SIZE); comparisons are unsigned, 12-bit, zero-extended counters, and must not overflow when x_l+SPRITE_SIZE exceeds 4095.
REQ-008 Stage 1 SHALL register rom_addr = {(vcount_in-y_l)[5:0], (hcount_in-x_l)[5:0]} when in_sprite, otherwise 12'h000.
REQ-009 The ROM returns data at edge E+1; stage 2 (edge E+1) SHALL carry timing, rgb_in and in_sprite forward unchanged.
REQ-010 Stage 3 (edge E+2) SHALL select pix = facing_left_l ? rom_rgb2 : rom_rgb.
REQ-011 rgb_out SHALL be:
- 12'h000 if delayed hblnk or vblnk is set;
- else pix if in_sprite && visible && pix!=TRANSPARENT;
- else delayed rgb_in.
REQ-012 Total latency from inputs to every output SHALL be exactly 3 clock edges (E, E+1, E+2), identical for all outputs.
REQ-013 The blink FSM SHALL have states IDLE, SHOW, HIDE; visible=0 only in HIDE.
REQ-014 blink_req in any state SHALL load frame_cnt=BLINK_FRAMES and phase_cnt=0, and enter HIDE on the next edge (restart if already blinking).
REQ-015 At each frame start in SHOW or HIDE, frame_cnt SHALL decrement and phase_cnt SHALL increment (mod 4). The FSM toggles SHOW<->HIDE when phase_cnt wraps 3->0, and goes to IDLE when frame_cnt reaches 0.
REQ-016 If blink_req coincides with frame start, blink_req SHALL win (reload), with no decrement that frame.
REQ-017 The FSM changes SHALL be sampled by pixel stage 1, so visibility switches at a frame boundary only.

Reset
REQ-018 On rst, all outputs, pipeline registers, rom_addr, latched x/y/facing, frame_cnt and phase_cnt SHALL be 0 and the FSM SHALL be IDLE, on the next edge.
REQ-019 rst asserted mid-frame SHALL flush the pipeline; outputs stay 0 until 3 edges after rst deasserts.
REQ-020 After reset, sprite position (0,0) SHALL be in effect until the next frame start.

Verification
REQ-021 xpos=100, ypos=50, pixel (hcount 110, vcount 60) -> rom_addr=12'h28A one edge later; rgb_out=rom_rgb value 3 edges after the input.
REQ-022 facing_left=1 latched at frame start -> rgb_out takes rom_rgb2. facing_left toggled mid-frame -> no change until the next frame.
REQ-023 ROM pixel = 12'hF0F inside the sprite -> rgb_out = rgb_in delayed. hblnk_in=1 -> rgb_out=12'h000 regardless of the sprite.
REQ-024 xpos=4090 -> no false hit at hcount 0..57; the sprite is drawn only at hcount>=4090 range within the counter width.
REQ-025 blink_req pulse -> sprite hidden for frames 1-4, shown 5-8, ... and back to IDLE (visible) after 60 frames. A second pulse at frame 10 restarts the 60-frame count.
REQ-026 rst at mid-line during a blink -> all outputs 0 next edge, FSM IDLE, sprite visible at (0,0) next frame.
